// File: rtl/pixel_window_loader.sv
// Assembles a scanline of 8-bit pixels into overlapping 48-pixel windows stepped by 32
// columns. The last window of each line is zero-padded; windows are offered on a valid/ready handshake.
module pixel_window_loader #(
    parameter int unsigned LINE_W = 640,
    parameter int unsigned WIN    = 48,
    parameter int unsigned STEP   = 32,
    parameter int unsigned CW     = $clog2(LINE_W)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    input  logic          pix_sol,
    output logic          pix_ready,
    output logic [7:0]    win_data [0:WIN-1],
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-1:0] win_base,
    output logic          win_last,
    output logic          sol_err
);

    // col also counts the trailing pads, so it needs headroom past LINE_W
    localparam int unsigned COL_W  = $clog2(LINE_W + STEP);
    localparam int unsigned NEED_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [NEED_W-1:0] need;
    logic              accept;
    logic              handoff;
    logic              shift_en;
    logic [7:0]        shift_val;

    assign accept  = pix_valid && pix_ready;
    assign handoff = win_valid && win_ready;

    // Select what, if anything, enters the window this cycle
    always_comb begin
        shift_en  = 1'b0;
        shift_val = pix_in;
        case (state)
            IDLE:    shift_en = accept && pix_sol;
            FILL:    shift_en = accept;
            PAD: begin
                shift_en  = 1'b1;
                shift_val = 8'h00;
            end
            default: shift_en = 1'b0;
        endcase
    end

    // Window shift register: entry k moves to k-1, new sample lands at the top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < WIN; k++) begin
                win_data[k] <= 8'h00;
            end
        end else if (shift_en) begin
            for (int k = 0; k < WIN - 1; k++) begin
                win_data[k] <= win_data[k+1];
            end
            win_data[WIN-1] <= shift_val;
        end
    end

    // Line sequencing FSM with registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            col       <= '0;
            need      <= '0;
            win_base  <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            sol_err   <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            sol_err <= 1'b0;
            case (state)
                IDLE: begin
                    pix_ready <= 1'b1;
                    if (accept && pix_sol) begin
                        col      <= COL_W'(1);
                        win_base <= '0;
                        need     <= NEED_W'(WIN - 1);
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (pix_sol) begin
                            // Mid-line start: this pixel becomes column 0 of a fresh line
                            sol_err  <= 1'b1;
                            col      <= COL_W'(1);
                            win_base <= '0;
                            need     <= NEED_W'(WIN - 1);
                        end else begin
                            col  <= col + COL_W'(1);
                            need <= need - NEED_W'(1);
                            if (need == NEED_W'(1)) begin
                                state     <= HOLD;
                                pix_ready <= 1'b0;
                                win_valid <= 1'b1;
                                win_last  <= (win_base == CW'(LINE_W - STEP));
                            end else if (col == COL_W'(LINE_W - 1)) begin
                                state     <= PAD;
                                pix_ready <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    col  <= col + COL_W'(1);
                    need <= need - NEED_W'(1);
                    if (need == NEED_W'(1)) begin
                        state     <= HOLD;
                        win_valid <= 1'b1;
                        win_last  <= (win_base == CW'(LINE_W - STEP));
                    end
                end
                HOLD: begin
                    if (handoff) begin
                        win_valid <= 1'b0;
                        win_last  <= 1'b0;
                        pix_ready <= 1'b1;
                        if (win_last) begin
                            state <= IDLE;
                            col   <= '0;
                        end else begin
                            win_base <= win_base + CW'(STEP);
                            need     <= NEED_W'(STEP);
                            state    <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_window_loader.sv
// Scoreboard bench for pixel_window_loader: a 64-wide and a 640-wide instance share the pixel
// bus; expected windows are queued at stimulus time and checked by per-instance monitors.
module tb_pixel_window_loader;

    typedef struct packed {
        logic [15:0]       base;
        logic              last;
        logic [47:0][7:0]  data;
    } win_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pix_in;
    logic       pix_sol;
    logic       pix_valid_a, pix_valid_b;
    logic       win_ready_a, win_ready_b;

    logic       pix_ready_a, win_valid_a, win_last_a, sol_err_a;
    logic [7:0] win_data_a [0:47];
    logic [5:0] win_base_a;
    logic       pix_ready_b, win_valid_b, win_last_b, sol_err_b;
    logic [7:0] win_data_b [0:47];
    logic [9:0] win_base_b;

    int vectors = 0;
    int miscompares = 0;
    int wins_a = 0;
    int wins_b = 0;
    int sol_cnt_a = 0;
    bit stall_done = 1'b0;
    win_t q_a[$];
    win_t q_b[$];
    win_t e_a, e_b;
    logic [47:0][7:0] d_a, d_b;

    always #5 clk = ~clk;

    pixel_window_loader #(.LINE_W(64)) dut_a (
        .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid_a),
        .pix_sol(pix_sol), .pix_ready(pix_ready_a), .win_data(win_data_a),
        .win_valid(win_valid_a), .win_ready(win_ready_a), .win_base(win_base_a),
        .win_last(win_last_a), .sol_err(sol_err_a)
    );

    pixel_window_loader #(.LINE_W(640)) dut_b (
        .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid_b),
        .pix_sol(pix_sol), .pix_ready(pix_ready_b), .win_data(win_data_b),
        .win_valid(win_valid_b), .win_ready(win_ready_b), .win_base(win_base_b),
        .win_last(win_last_b), .sol_err(sol_err_b)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic win_t exp_win(input int base, input int lw, input int offs);
        win_t w;
        w.base = 16'(base);
        w.last = (base == lw - 32);
        for (int k = 0; k < 48; k++) begin
            w.data[k] = (base + k < lw) ? 8'(base + k + offs) : 8'h00;
        end
        return w;
    endfunction

    task automatic push_line(input bit to_b, input int lw, input int offs);
        for (int b = 0; b < lw; b += 32) begin
            if (to_b) q_b.push_back(exp_win(b, lw, offs));
            else      q_a.push_back(exp_win(b, lw, offs));
        end
    endtask

    task automatic cmp_win(input string tag, input int base, input int last, input int pr,
                           input logic [47:0][7:0] d, input win_t e);
        int nerr = 0;
        for (int k = 0; k < 48; k++) begin
            if (d[k] != e.data[k]) nerr++;
        end
        check({tag, "_base"}, base, int'(e.base));
        check({tag, "_last"}, last, int'(e.last));
        check({tag, "_data_bytes_wrong"}, nerr, 0);
        check({tag, "_pix_ready_in_hold"}, pr, 0);
    endtask

    // Monitor A: compare the presented window every cycle it is valid, pop on handoff
    always @(negedge clk) begin
        if (reset_n && win_valid_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_window_base", int'(win_base_a), -1);
            end else begin
                e_a = q_a[0];
                for (int k = 0; k < 48; k++) d_a[k] = win_data_a[k];
                cmp_win("a", int'(win_base_a), int'(win_last_a), int'(pix_ready_a), d_a, e_a);
                if (win_ready_a) begin
                    void'(q_a.pop_front());
                    wins_a++;
                end
            end
        end
        if (reset_n && sol_err_a) sol_cnt_a++;
    end

    // Monitor B
    always @(negedge clk) begin
        if (reset_n && win_valid_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_window_base", int'(win_base_b), -1);
            end else begin
                e_b = q_b[0];
                for (int k = 0; k < 48; k++) d_b[k] = win_data_b[k];
                cmp_win("b", int'(win_base_b), int'(win_last_b), int'(pix_ready_b), d_b, e_b);
                if (win_ready_b) begin
                    void'(q_b.pop_front());
                    wins_b++;
                end
            end
        end
    end

    // Downstream stall: hold win_ready_b low for 10 cycles on window 3 (base 96)
    always @(posedge clk) begin
        #1;
        if (!stall_done && win_valid_b && win_base_b == 10'd96) begin
            stall_done  = 1'b1;
            win_ready_b = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            win_ready_b = 1'b1;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit to_b, input logic [7:0] v, input bit sol);
        int n = 0;
        pix_in  = v;
        pix_sol = sol;
        if (to_b) pix_valid_b = 1'b1;
        else      pix_valid_a = 1'b1;
        forever begin
            @(negedge clk);
            if ((to_b ? pix_ready_b : pix_ready_a) == 1'b1) break;
            n++;
            if (n > 1000) begin
                check("send_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        pix_valid_a = 1'b0;
        pix_valid_b = 1'b0;
        pix_sol     = 1'b0;
    endtask

    task automatic send_line(input bit to_b, input int offs, input int from_col,
                             input int to_col, input bit rnd);
        for (int c = from_col; c < to_col; c++) begin
            if (rnd && $urandom_range(0, 1) == 1) sync();
            send(to_b, 8'(c + offs), c == 0);
        end
    endtask

    task automatic wait_empty(input bit to_b);
        int n = 0;
        while ((to_b ? q_b.size() : q_a.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(to_b ? "b_drain_left" : "a_drain_left", to_b ? q_b.size() : q_a.size(), 0);
        repeat (3) sync();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        reset_n     = 1'b0;
        pix_in      = 8'h00;
        pix_sol     = 1'b0;
        pix_valid_a = 1'b0;
        pix_valid_b = 1'b0;
        win_ready_a = 1'b1;
        win_ready_b = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 48; k++) begin
            if (win_data_a[k] != 8'h00) n++;
            if (win_data_b[k] != 8'h00) n++;
        end
        check("rst_pix_ready_a", int'(pix_ready_a), 0);
        check("rst_pix_ready_b", int'(pix_ready_b), 0);
        check("rst_win_valid_a", int'(win_valid_a), 0);
        check("rst_win_valid_b", int'(win_valid_b), 0);
        check("rst_win_data_nonzero", n, 0);
        check("rst_win_base_a", int'(win_base_a), 0);
        check("rst_win_last_a", int'(win_last_a), 0);
        check("rst_sol_err_a", int'(sol_err_a), 0);
        sync();
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_pix_ready_a", int'(pix_ready_a), 1);
        check("post_rst_pix_ready_b", int'(pix_ready_b), 1);
        sync();

        // 64-wide continuous ramp; the tail is 16 pads plus one hold cycle
        push_line(1'b0, 64, 0);
        send_line(1'b0, 0, 0, 64, 1'b0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pix_ready_a) break;
            n++;
        end
        check("a_tail_ready_low_cycles", n, 17);
        sync();
        wait_empty(1'b0);
        check("a_windows_line1", wins_a, 2);

        // Same line with gappy pix_valid
        push_line(1'b0, 64, 0);
        send_line(1'b0, 0, 0, 64, 1'b1);
        wait_empty(1'b0);
        check("a_windows_line2", wins_a, 4);
        check("a_sol_err_quiet", sol_cnt_a, 0);

        // Restart mid-line at column 20 with a new line offset by 0x80
        send_line(1'b0, 0, 0, 20, 1'b0);
        push_line(1'b0, 64, 128);
        send_line(1'b0, 128, 0, 64, 1'b0);
        wait_empty(1'b0);
        check("a_sol_err_cycles", sol_cnt_a, 1);
        check("a_windows_restart", wins_a, 6);

        // Stray pixels in IDLE are dropped without producing a window
        w0 = wins_a;
        for (int i = 0; i < 5; i++) send(1'b0, 8'(i + 1), 1'b0);
        repeat (80) sync();
        check("a_stray_no_window", wins_a, w0);

        // 640-wide ramp with a 10-cycle stall on window 3
        push_line(1'b1, 640, 0);
        send_line(1'b1, 0, 0, 640, 1'b0);
        wait_empty(1'b1);
        check("b_window_count", wins_b, 20);
        check("b_stall_seen", int'(stall_done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
